// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes
//   Iterative AES inverse SubBytes for the decryption datapath. All 16 byte
//   lanes run in parallel. Each lane applies the inverse affine transform to
//   its input byte, giving a. It then forms a^254, the GF(2^8) multiplicative
//   inverse, by repeated square-and-multiply over 7 clock cycles.
//
// Ports
//   clk    in   1    system clock, rising edge
//   n_rst  in   1    synchronous active-low reset
//   start  in   1    request, sampled only while idle
//   in     in   128  state from inv_shift_rows, lane i = in[127-8i -: 8]
//   out    out  128  inverse-substituted state, held until the next completion
//   busy   out  1    high while a computation is in progress
//   done   out  1    single-cycle pulse marking out as newly valid
module inv_sub_bytes (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t     state;
  logic [2:0] cnt;

  // r accumulates the product of the odd powers. p walks a^2, a^4, ..., a^128.
  logic [7:0] r [16];
  logic [7:0] p [16];

  logic [7:0] a_lane [16];
  logic [7:0] a_sq   [16];
  logic [7:0] rp     [16];
  logic [7:0] pp     [16];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, using shift-and-add with xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] b;
    acc = 8'h00;
    b   = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) acc = acc ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse of the S-box affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // Each lane has one squarer for capture, one r*p multiplier and one p*p multiplier.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      a_lane[i] = inv_affine(in[127-8*i -: 8]);
      a_sq[i]   = gf_mul(a_lane[i], a_lane[i]);
      rp[i]     = gf_mul(r[i], p[i]);
      pp[i]     = gf_mul(p[i], p[i]);
    end
  end

  assign busy = (state == CALC);

  // Capture: r = 1 and p = a^2. Each CALC cycle folds p into r and squares p.
  // The seventh iteration (cnt == 6) writes r*p = a^(2+4+...+128) = a^254
  // straight to out. An input of zero naturally yields zero.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      out   <= '0;
      done  <= 1'b0;
      cnt   <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        r[i] <= 8'h00;
        p[i] <= 8'h00;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              r[i] <= 8'h01;
              p[i] <= a_sq[i];
            end
            cnt   <= 3'd0;
            state <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < 16; i++) begin
            r[i] <= rp[i];
            p[i] <= pp[i];
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd6) begin
            for (int i = 0; i < 16; i++) begin
              out[127-8*i -: 8] <= rp[i];
            end
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes
//   Self-checking bench for inv_sub_bytes.
//
//   The reference inverse S-box is derived from first principles:
//     1. Find each multiplicative inverse by exhaustive search, using
//        polynomial multiplication followed by reduction mod 0x11B.
//     2. Apply the forward affine map to obtain the forward S-box.
//     3. Invert that table.
//
//   A cycle-level reference tracks the accept/latency/done behaviour. A
//   forked process compares out, busy and done against it on every cycle.
//   Directed tests pin literal FIPS-197 values.
module tb_inv_sub_bytes;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [127:0] in;
  logic [127:0] out;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  int done_seen;
  bit cmp_en;

  logic [7:0] inv_sbox [256];

  // Cycle-level reference state.
  logic [127:0] m_out;
  logic [127:0] m_pend;
  logic         m_done;
  int           m_rem;

  inv_sub_bytes dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial multiply in GF(2)[x], then reduce modulo 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int k = 0; k < 8; k++)
      if (y[k]) prod = prod ^ (16'(x) << k);
    for (int k = 15; k >= 8; k--)
      if (prod[k]) prod = prod ^ (16'h011b << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] v);
    logic [127:0] res;
    for (int i = 0; i < 16; i++)
      res[127-8*i -: 8] = inv_sbox[v[127-8*i -: 8]];
    return res;
  endfunction

  // Result is due 7 edges after acceptance. Reset clears everything.
  always @(posedge clk) begin
    if (!n_rst) begin
      m_out  <= '0;
      m_done <= 1'b0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_out  <= m_pend;
          m_done <= 1'b1;
        end
      end else if (start) begin
        m_pend <= ref_sub(in);
        m_rem  <= 7;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] v);
    @(negedge clk);
    in    = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge after the accepting edge.
  // Returns the negedge count at which done was seen, plus busy cycles observed.
  task automatic waitDone(output int lat, output int busy_cyc);
    lat      = 1;
    busy_cyc = 0;
    forever begin
      if (busy) busy_cyc++;
      if (done) break;
      if (lat >= 20) begin
        checkOutput("done_timeout", 128'(lat), 128'(8));
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runDirected(input string name, input logic [127:0] v, input logic [127:0] exp);
    int lat;
    int bc;
    applyStimulus(v);
    waitDone(lat, bc);
    checkOutput({name, "_out"}, out, exp);
    checkOutput({name, "_latency"}, 128'(lat - 1), 128'(7));
    checkOutput({name, "_busy_cycles"}, 128'(bc), 128'(7));
  endtask

  initial begin
    logic [127:0] c1_in;
    logic [127:0] c1_out;
    logic [127:0] v;
    int           lat;
    int           bc;
    int           d0;
    realtime      t1;
    realtime      t2;

    c1_in  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    c1_out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    checks = 0;
    errors = 0;
    done_seen = 0;
    cmp_en = 1'b0;
    n_rst  = 1'b0;
    start  = 1'b0;
    in     = '0;

    // Build the reference inverse S-box.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_sbox[s] = 8'(x);
    end

    // Pin the reference model to known values.
    checkOutput("model_63", 128'(inv_sbox[8'h63]), 128'h00);
    checkOutput("model_00", 128'(inv_sbox[8'h00]), 128'h52);
    checkOutput("model_01", 128'(inv_sbox[8'h01]), 128'h09);
    checkOutput("model_52", 128'(inv_sbox[8'h52]), 128'h48);
    checkOutput("model_c1", ref_sub(c1_in), c1_out);

    // Per-cycle compare against the cycle-level reference.
    fork
      forever begin
        @(negedge clk);
        if (done) done_seen++;
        if (cmp_en) begin
          checkOutput("cyc_out", out, m_out);
          checkOutput("cyc_busy", 128'(busy), 128'(m_rem != 0));
          checkOutput("cyc_done", 128'(done), 128'(m_done));
        end
      end
    join_none

    // Reset with start raised: nothing may be accepted.
    start = 1'b1;
    in    = c1_in;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_out", out, '0);
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 round 1, plus edge values.
    d0 = done_seen;
    runDirected("c1", c1_in, c1_out);
    @(negedge clk);
    checkOutput("c1_done_once", 128'(done_seen - d0), 128'(1));
    runDirected("all63", {16{8'h63}}, {16{8'h00}});
    runDirected("all00", {16{8'h00}}, {16{8'h52}});
    runDirected("all01", {16{8'h01}}, {16{8'h09}});
    runDirected("all52", {16{8'h52}}, {16{8'h48}});

    // Busy protection: new input and a start pulse during CALC are ignored.
    applyStimulus({16{8'h01}});
    repeat (2) @(negedge clk);
    in    = c1_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, bc);
    checkOutput("busyprot_out", out, {16{8'h09}});
    repeat (3) @(negedge clk);
    checkOutput("busyprot_no_rerun", 128'(busy), 128'(0));

    // Reset mid-operation: n_rst low at E4.
    d0 = done_seen;
    applyStimulus({16{8'h63}});
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midreset_no_done", 128'(done_seen - d0), 128'(0));
    checkOutput("midreset_out", out, '0);
    runDirected("after_reset", c1_in, c1_out);

    // Back-to-back: start held high for two consecutive accepts.
    @(negedge clk);
    in    = c1_in;
    start = 1'b1;
    @(negedge clk);
    in = {16{8'h52}};
    waitDone(lat, bc);
    t1 = $realtime;
    checkOutput("b2b_first_out", out, c1_out);
    @(negedge clk);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    t2 = $realtime;
    start = 1'b0;
    checkOutput("b2b_second_out", out, {16{8'h48}});
    checkOutput("b2b_gap", 128'(int'((t2 - t1) / 10.0)), 128'(8));
    repeat (10) @(negedge clk);

    // Random phase: random gaps, ignored mid-CALC starts and mid-op resets.
    for (int t = 0; t < 40; t++) begin
      int mode;
      v = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(v);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        in    = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
      end
      repeat (9) @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
